// File: rtl/note_judge.sv
`default_nettype none
// ============================================================================
// Module   : note_judge
// Purpose  : Per-track note queues, key-press matching and judgement/score.
// Revision : 1.0 - initial release
// ============================================================================
module note_judge #(
   parameter int unsigned DEPTH       = 8,
   parameter int unsigned TRAVEL_MS   = 2000,
   parameter int unsigned PERFECT_WIN = 50,
   parameter int unsigned GOOD_WIN    = 150,
   parameter int unsigned PERFECT_PTS = 100,
   parameter int unsigned GOOD_PTS    = 50
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] i_cur_time,
   input  logic        i_note_t1,
   input  logic        i_note_t2,
   input  logic        i_key_t1,
   input  logic        i_key_t2,
   output logic        o_judge_valid,
   output logic [1:0]  o_judge_code,
   output logic        o_judge_track,
   output logic [15:0] o_score,
   output logic [15:0] o_combo,
   output logic        o_overflow
);

   localparam int          c_aw      = $clog2(DEPTH);
   localparam logic [c_aw:0] c_full  = (c_aw + 1)'(DEPTH);
   localparam logic [1:0]  c_perfect = 2'd1;
   localparam logic [1:0]  c_good    = 2'd2;
   localparam logic [1:0]  c_miss    = 2'd3;

   typedef enum logic [0:0] {SVC_T1 = 1'b0, SVC_T2 = 1'b1} svc_t;

   svc_t              r_state;
   logic [31:0]       r_mem [2][DEPTH];
   logic [c_aw-1:0]   r_rd  [2];
   logic [c_aw-1:0]   r_wr  [2];
   logic [c_aw:0]     r_cnt [2];
   logic [1:0]        r_pend;

   logic              w_trk;
   logic [31:0]       w_head;
   logic              w_has;
   logic              w_late;
   logic [31:0]       w_err;
   logic              w_pop;
   logic              w_clr;
   logic [1:0]        w_code;
   logic [1:0]        w_popv;
   logic [1:0]        w_clrv;
   logic [1:0]        w_push;
   logic [1:0]        w_drop;
   logic [1:0]        w_note;
   logic [1:0]        w_key;
   logic [16:0]       w_pts;
   logic [16:0]       w_score_sum;
   logic [16:0]       w_combo_sum;

   assign w_note = {i_note_t2, i_note_t1};
   assign w_key  = {i_key_t2, i_key_t1};
   assign w_trk  = (r_state == SVC_T2);

   always_comb begin
      w_head = r_mem[w_trk][r_rd[w_trk]];
      w_has  = (r_cnt[w_trk] != '0);
      // 33-bit compare so head + GOOD_WIN cannot wrap
      w_late = w_has && ({1'b0, i_cur_time} > ({1'b0, w_head} + 33'(GOOD_WIN)));
      w_err  = (i_cur_time >= w_head) ? (i_cur_time - w_head) : (w_head - i_cur_time);
      w_pop  = 1'b0;
      w_clr  = 1'b0;
      w_code = 2'd0;
      if (w_late) begin
         w_pop  = 1'b1;
         w_code = c_miss;
      end else if (r_pend[w_trk]) begin
         w_clr = 1'b1;
         if (w_has && (w_err <= 32'(PERFECT_WIN))) begin
            w_pop  = 1'b1;
            w_code = c_perfect;
         end else if (w_has && (w_err <= 32'(GOOD_WIN))) begin
            w_pop  = 1'b1;
            w_code = c_good;
         end
      end
      w_popv        = 2'b00;
      w_popv[w_trk] = w_pop;
      w_clrv        = 2'b00;
      w_clrv[w_trk] = w_clr;
      for (int t = 0; t < 2; t++) begin
         w_push[t] = w_note[t] && ((r_cnt[t] != c_full) || w_popv[t]);
         w_drop[t] = w_note[t] && !w_push[t];
      end
      w_pts       = (w_code == c_perfect) ? 17'(PERFECT_PTS) : 17'(GOOD_PTS);
      w_score_sum = {1'b0, o_score} + w_pts;
      w_combo_sum = {1'b0, o_combo} + 17'd1;
   end

   // Queue storage needs no reset: the counts define what is valid.
   always_ff @(posedge clk) begin
      for (int t = 0; t < 2; t++) begin
         if (w_push[t]) begin
            r_mem[t][r_wr[t]] <= i_cur_time + 32'(TRAVEL_MS);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state       <= SVC_T1;
         r_pend        <= 2'b00;
         for (int t = 0; t < 2; t++) begin
            r_rd[t]  <= '0;
            r_wr[t]  <= '0;
            r_cnt[t] <= '0;
         end
         o_judge_valid <= 1'b0;
         o_judge_code  <= 2'd0;
         o_judge_track <= 1'b0;
         o_score       <= 16'd0;
         o_combo       <= 16'd0;
         o_overflow    <= 1'b0;
      end else begin
         r_state <= (r_state == SVC_T1) ? SVC_T2 : SVC_T1;
         for (int t = 0; t < 2; t++) begin
            if (w_popv[t]) r_rd[t] <= r_rd[t] + c_aw'(1);
            if (w_push[t]) r_wr[t] <= r_wr[t] + c_aw'(1);
            r_cnt[t] <= r_cnt[t] + (c_aw + 1)'(w_push[t]) - (c_aw + 1)'(w_popv[t]);
         end
         // A fresh key wins over a same-cycle clear so no press is lost
         r_pend        <= (r_pend & ~w_clrv) | w_key;
         o_overflow    <= o_overflow | (|w_drop);
         o_judge_valid <= w_pop;
         o_judge_code  <= w_code;
         o_judge_track <= w_pop & w_trk;
         if (w_code == c_miss) begin
            o_combo <= 16'd0;
         end else if (w_pop) begin
            o_score <= w_score_sum[16] ? 16'hFFFF : w_score_sum[15:0];
            o_combo <= w_combo_sum[16] ? 16'hFFFF : w_combo_sum[15:0];
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_note_judge.sv
`default_nettype none
// ============================================================================
// Module   : tb_note_judge
// Purpose  : Scenario tasks plus randomized run against a queue-based model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_note_judge;

   localparam int unsigned DEPTH = 8, TRAVEL = 2000, PW = 50, GW = 150, PP = 100, GP = 50;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] cur = 32'd0;
   logic        nt1 = 1'b0, nt2 = 1'b0, k1 = 1'b0, k2 = 1'b0;
   logic        o_judge_valid;
   logic [1:0]  o_judge_code;
   logic        o_judge_track;
   logic [15:0] o_score, o_combo;
   logic        o_overflow;

   note_judge #(
      .DEPTH(DEPTH), .TRAVEL_MS(TRAVEL), .PERFECT_WIN(PW),
      .GOOD_WIN(GW), .PERFECT_PTS(PP), .GOOD_PTS(GP)
   ) dut (
      .clk(clk), .rst(rst), .i_cur_time(cur),
      .i_note_t1(nt1), .i_note_t2(nt2), .i_key_t1(k1), .i_key_t2(k2),
      .o_judge_valid(o_judge_valid), .o_judge_code(o_judge_code),
      .o_judge_track(o_judge_track), .o_score(o_score), .o_combo(o_combo),
      .o_overflow(o_overflow)
   );

   always #5 clk = ~clk;

   int n_cmp = 0, n_fail = 0;

   // Reference model: note targets held as plain queues per track
   int unsigned mq [2][$];
   bit          mpend [2];
   bit          mphase;
   bit          m_valid, m_track, m_ovf;
   bit [1:0]    m_code;
   int          m_score, m_combo;

   int          s_cnt;
   bit [1:0]    s_code, s_tracks;
   bit          s_track;

   task automatic tick();
      bit [1:0] notes, keys;
      longint   c, h, e;
      int       t, pts;
      @(posedge clk);
      notes = {nt2, nt1};
      keys  = {k2, k1};
      c     = longint'(cur);
      m_valid = 0; m_code = 0; m_track = 0;
      if (rst) begin
         mq[0].delete(); mq[1].delete();
         mpend[0] = 0; mpend[1] = 0; mphase = 0;
         m_score = 0; m_combo = 0; m_ovf = 0;
      end else begin
         t = int'(mphase);
         if (mq[t].size() > 0 && c > longint'(mq[t][0]) + longint'(GW)) begin
            void'(mq[t].pop_front());
            m_valid = 1; m_code = 3; m_track = mphase; m_combo = 0;
         end else if (mpend[t]) begin
            mpend[t] = 0;
            if (mq[t].size() > 0) begin
               h = longint'(mq[t][0]);
               e = (c > h) ? c - h : h - c;
               if (e <= longint'(GW)) begin
                  void'(mq[t].pop_front());
                  m_valid = 1; m_track = mphase;
                  m_code  = (e <= longint'(PW)) ? 2'd1 : 2'd2;
                  pts     = (e <= longint'(PW)) ? int'(PP) : int'(GP);
                  m_score = (m_score + pts > 65535) ? 65535 : m_score + pts;
                  m_combo = (m_combo + 1 > 65535) ? 65535 : m_combo + 1;
               end
            end
         end
         for (int i = 0; i < 2; i++) begin
            if (notes[i]) begin
               if (mq[i].size() < DEPTH) mq[i].push_back(cur + 32'(TRAVEL));
               else m_ovf = 1;
            end
            if (keys[i]) mpend[i] = 1;
         end
         mphase = !mphase;
      end
      #1;
      if (o_judge_valid) begin
         s_cnt++;
         s_code = o_judge_code;
         s_track = o_judge_track;
         s_tracks[o_judge_track] = 1'b1;
      end
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic pulse(input bit a1, input bit a2, input bit b1, input bit b2);
      nt1 = a1; nt2 = a2; k1 = b1; k2 = b2;
      tick();
      nt1 = 0; nt2 = 0; k1 = 0; k2 = 0;
   endtask

   task automatic clr_obs();
      s_cnt = 0; s_code = 0; s_track = 0; s_tracks = 0;
   endtask

   task automatic do_reset();
      rst = 1; tick(); rst = 0;
   endtask

   task automatic test_reset();
      rst = 1; nt1 = 1; k2 = 1; cur = 32'd5;
      run(2);
      nt1 = 0; k2 = 0;
      n_cmp += 6;
      if (o_judge_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %0b want 0", o_judge_valid); end
      if (o_judge_code !== 2'd0) begin n_fail++; $display("FAIL reset_code: got %0d want 0", o_judge_code); end
      if (o_judge_track !== 1'b0) begin n_fail++; $display("FAIL reset_track: got %0b want 0", o_judge_track); end
      if (o_score !== 16'd0) begin n_fail++; $display("FAIL reset_score: got %0d want 0", o_score); end
      if (o_combo !== 16'd0) begin n_fail++; $display("FAIL reset_combo: got %0d want 0", o_combo); end
      if (o_overflow !== 1'b0) begin n_fail++; $display("FAIL reset_ovf: got %0b want 0", o_overflow); end
      rst = 0;
   endtask

   task automatic test_perfect();
      do_reset();
      cur = 32'd1000; pulse(1, 0, 0, 0);
      cur = 32'd3030; clr_obs(); pulse(0, 0, 1, 0); run(4);
      n_cmp += 5;
      if (s_cnt !== 1) begin n_fail++; $display("FAIL perfect_count: got %0d want 1", s_cnt); end
      if (s_code !== 2'd1) begin n_fail++; $display("FAIL perfect_code: got %0d want 1", s_code); end
      if (s_track !== 1'b0) begin n_fail++; $display("FAIL perfect_track: got %0d want 0", s_track); end
      if (o_score !== 16'd100) begin n_fail++; $display("FAIL perfect_score: got %0d want 100", o_score); end
      if (o_combo !== 16'd1) begin n_fail++; $display("FAIL perfect_combo: got %0d want 1", o_combo); end
      cur = 32'd5000; clr_obs(); run(4);
      n_cmp++;
      if (s_cnt !== 0) begin n_fail++; $display("FAIL perfect_empty: got %0d strobes want 0", s_cnt); end
   endtask

   task automatic test_good_miss();
      do_reset();
      cur = 32'd1000; pulse(0, 1, 0, 0);
      cur = 32'd1100; pulse(0, 1, 0, 0);
      cur = 32'd3120; clr_obs(); pulse(0, 0, 0, 1); run(4);
      n_cmp += 4;
      if (s_cnt !== 1) begin n_fail++; $display("FAIL good_count: got %0d want 1", s_cnt); end
      if (s_code !== 2'd2) begin n_fail++; $display("FAIL good_code: got %0d want 2", s_code); end
      if (s_track !== 1'b1) begin n_fail++; $display("FAIL good_track: got %0d want 1", s_track); end
      if (o_score !== 16'd50) begin n_fail++; $display("FAIL good_score: got %0d want 50", o_score); end
      cur = 32'd3250; clr_obs(); run(6);
      n_cmp++;
      if (s_cnt !== 0) begin n_fail++; $display("FAIL miss_edge: got %0d strobes want 0", s_cnt); end
      cur = 32'd3251; clr_obs(); run(3);
      n_cmp += 3;
      if (s_cnt !== 1) begin n_fail++; $display("FAIL miss_count: got %0d want 1", s_cnt); end
      if (s_code !== 2'd3) begin n_fail++; $display("FAIL miss_code: got %0d want 3", s_code); end
      if (o_combo !== 16'd0) begin n_fail++; $display("FAIL miss_combo: got %0d want 0", o_combo); end
   endtask

   task automatic test_early_empty();
      do_reset();
      cur = 32'd1000; pulse(1, 0, 0, 0);
      cur = 32'd2500; clr_obs(); pulse(0, 0, 1, 0); run(4);
      n_cmp++;
      if (s_cnt !== 0) begin n_fail++; $display("FAIL early_count: got %0d want 0", s_cnt); end
      cur = 32'd3000; clr_obs(); pulse(0, 0, 1, 0); run(4);
      n_cmp += 2;
      if (s_cnt !== 1) begin n_fail++; $display("FAIL retained_count: got %0d want 1", s_cnt); end
      if (s_code !== 2'd1) begin n_fail++; $display("FAIL retained_code: got %0d want 1", s_code); end
      cur = 32'd3010; clr_obs(); pulse(0, 0, 1, 0); run(4);
      n_cmp += 2;
      if (s_cnt !== 0) begin n_fail++; $display("FAIL empty_count: got %0d want 0", s_cnt); end
      if (o_score !== 16'd100) begin n_fail++; $display("FAIL empty_score: got %0d want 100", o_score); end
   endtask

   task automatic test_overflow();
      do_reset();
      for (int i = 0; i < 9; i++) begin
         cur = 32'(i); pulse(1, 0, 0, 0);
         if (i == 7) begin
            n_cmp++;
            if (o_overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_early: got %0b want 0", o_overflow); end
         end
      end
      n_cmp++;
      if (o_overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_set: got %0b want 1", o_overflow); end
      cur = 32'd2150; clr_obs(); run(6);
      n_cmp++;
      if (s_cnt !== 0) begin n_fail++; $display("FAIL ovf_premiss: got %0d want 0", s_cnt); end
      cur = 32'd2160; clr_obs(); run(24);
      n_cmp += 3;
      if (s_cnt !== 8) begin n_fail++; $display("FAIL ovf_misses: got %0d want 8", s_cnt); end
      if (s_code !== 2'd3) begin n_fail++; $display("FAIL ovf_code: got %0d want 3", s_code); end
      if (o_overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky: got %0b want 1", o_overflow); end
   endtask

   task automatic test_simultaneous();
      do_reset();
      cur = 32'd1000; pulse(1, 1, 0, 0);
      cur = 32'd3000; clr_obs(); pulse(0, 0, 1, 1); run(4);
      n_cmp += 4;
      if (s_cnt !== 2) begin n_fail++; $display("FAIL simul_count: got %0d want 2", s_cnt); end
      if (s_tracks !== 2'b11) begin n_fail++; $display("FAIL simul_tracks: got %b want 11", s_tracks); end
      if (o_score !== 16'd200) begin n_fail++; $display("FAIL simul_score: got %0d want 200", o_score); end
      if (o_combo !== 16'd2) begin n_fail++; $display("FAIL simul_combo: got %0d want 2", o_combo); end
   endtask

   task automatic test_reset_midplay();
      do_reset();
      cur = 32'd1000; pulse(1, 0, 0, 0);
      cur = 32'd3000; pulse(0, 0, 1, 0); run(3);
      for (int i = 0; i < 3; i++) begin cur = 32'(3100 + i); pulse(1, 0, 0, 0); end
      cur = 32'd3200; pulse(0, 0, 1, 0);
      rst = 1; tick(); rst = 0;
      n_cmp += 3;
      if (o_score !== 16'd0) begin n_fail++; $display("FAIL mid_score: got %0d want 0", o_score); end
      if (o_combo !== 16'd0) begin n_fail++; $display("FAIL mid_combo: got %0d want 0", o_combo); end
      if (o_judge_valid !== 1'b0) begin n_fail++; $display("FAIL mid_valid: got %0b want 0", o_judge_valid); end
      cur = 32'd9000; clr_obs(); run(10);
      n_cmp++;
      if (s_cnt !== 0) begin n_fail++; $display("FAIL mid_flushed: got %0d strobes want 0", s_cnt); end
   endtask

   task automatic test_saturate();
      int unsigned base = 10000;
      do_reset();
      for (int i = 0; i < 700; i++) begin
         cur = base; pulse(1, 0, 0, 0);
         cur = base + TRAVEL + $urandom_range(0, PW);
         pulse(0, 0, 1, 0); run(2);
         base += 3000;
      end
      n_cmp += 2;
      if (o_score !== 16'hFFFF) begin n_fail++; $display("FAIL sat_score: got %0d want 65535", o_score); end
      if (o_combo !== 16'd700) begin n_fail++; $display("FAIL sat_combo: got %0d want 700", o_combo); end
   endtask

   task automatic test_random();
      do_reset();
      for (int i = 0; i < 4000; i++) begin
         cur = cur + 32'($urandom_range(0, 20));
         nt1 = ($urandom_range(0, 9) == 0);
         nt2 = ($urandom_range(0, 9) == 0);
         k1  = ($urandom_range(0, 5) == 0);
         k2  = ($urandom_range(0, 5) == 0);
         rst = ($urandom_range(0, 999) == 0);
         tick();
         n_cmp++;
         if ({o_judge_valid, o_judge_code, o_judge_track, o_score, o_combo, o_overflow} !==
             {m_valid, m_code, m_track, 16'(m_score), 16'(m_combo), m_ovf}) begin
            n_fail++;
            $display("FAIL random_cycle%0d: got v%0b c%0d t%0b s%0d cb%0d o%0b want v%0b c%0d t%0b s%0d cb%0d o%0b",
                     i, o_judge_valid, o_judge_code, o_judge_track, o_score, o_combo, o_overflow,
                     m_valid, m_code, m_track, m_score, m_combo, m_ovf);
         end
      end
      nt1 = 0; nt2 = 0; k1 = 0; k2 = 0; rst = 0;
   endtask

   initial begin
      clr_obs();
      test_reset();
      test_perfect();
      test_good_miss();
      test_early_empty();
      test_overflow();
      test_simultaneous();
      test_reset_midplay();
      test_saturate();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
